// File: rtl/ibex_data_mem_responder_if.sv
// ibex_data_mem_responder_if: ibex data-side req/gnt/rvalid bus, named from the responder's view.
interface ibex_data_mem_responder_if;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    modport master (
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );
    modport slave (
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );
endinterface

// File: rtl/ibex_data_mem_responder.sv
// ibex_data_mem_responder: word SRAM behind the ibex data bus with a programmable grant stall,
// fixed-latency in-order responses, byte-enable writes and out-of-range error responses.
module ibex_data_mem_responder #(
    parameter int unsigned MemWords       = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0010_0000,
    parameter int unsigned GntDelay       = 0,
    parameter int unsigned RspLatency     = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input logic                      clk_i,
    input logic                      rst_ni,
    ibex_data_mem_responder_if.slave bus
);
    localparam int unsigned IdxW = $clog2(MemWords);

    logic [31:0]                 mem_q [MemWords];
    logic [31:0]                 off;
    logic [IdxW-1:0]             idx;
    logic                        in_range, gnt, rvalid;
    logic [2:0]                  wait_q, wait_d, out_q, out_d;
    logic [RspLatency-1:0]       vld_q, err_q;
    logic [RspLatency-1:0][31:0] rdata_q;
    logic [31:0]                 rdata_d;

    // A response retiring this cycle frees its slot, so MaxOutstanding == RspLatency sustains one grant per cycle.
    always_comb begin
        off      = bus.data_addr_i - BaseAddr;
        idx      = off[IdxW+1:2];
        in_range = (off >> 2) < 32'(MemWords);
        rvalid   = vld_q[RspLatency-1];
        gnt      = rst_ni & bus.data_req_i & ({1'b0, wait_q} + 4'd1 > 4'(GntDelay))
                 & ((32'(out_q) < MaxOutstanding) | rvalid);
        wait_d   = (!bus.data_req_i || gnt) ? 3'd0 : (wait_q == 3'd7 ? wait_q : wait_q + 3'd1);
        out_d    = out_q + {2'b0, gnt} - {2'b0, rvalid};
        rdata_d  = (gnt && in_range && !bus.data_we_i) ? mem_q[idx] : 32'h0;
    end

    assign bus.data_gnt_o    = gnt;
    assign bus.data_rvalid_o = rvalid;
    assign bus.data_err_o    = err_q[RspLatency-1];
    assign bus.data_rdata_o  = rdata_q[RspLatency-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_q  <= '0;
            out_q   <= '0;
            vld_q   <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            wait_q  <= wait_d;
            out_q   <= out_d;
            vld_q   <= RspLatency'({vld_q, gnt});
            err_q   <= RspLatency'({err_q, gnt & !in_range});
            rdata_q <= (32*RspLatency)'({rdata_q, rdata_d});
        end
    end

    // Array has no reset so its contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (gnt && in_range && bus.data_we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_be_i[i]) mem_q[idx][8*i +: 8] <= bus.data_wdata_i[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ibex_data_mem_responder.sv
// tb_ibex_data_mem_responder: four responders with different stall/latency settings, each checked
// against a behavioural memory model and an in-order response scoreboard.
module tb_ibex_data_mem_responder;
    localparam logic [31:0] BASE = 32'h0010_0000;
    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;
    logic [3:0]  req = '0;
    logic [3:0]  we = '0;
    logic [3:0]  gnt, rvalid, err;
    logic [3:0]  be [4];
    logic [31:0] addr [4];
    logic [31:0] wdata [4];
    logic [31:0] rdata [4];
    logic [31:0] last_rd [4];
    logic        last_err [4];
    int          rv_cnt [4];
    int          bg [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Instance 0: defaults; 1: GntDelay 3 / RspLatency 2; 2: RspLatency 3; 3: RspLatency 4.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned GD = (g == 1) ? 3 : 0;
        localparam int unsigned RL = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 4;
        exp_t        q [$];
        exp_t        e;
        logic [31:0] mdl [logic [31:0]];
        logic [31:0] off, wi, cur;
        ibex_data_mem_responder_if bus ();
        ibex_data_mem_responder #(.GntDelay(GD), .RspLatency(RL), .MaxOutstanding(2)) u_dut (
            .clk_i (clk),
            .rst_ni(rst_n),
            .bus   (bus.slave)
        );
        assign bus.data_req_i   = req[g];
        assign bus.data_we_i    = we[g];
        assign bus.data_be_i    = be[g];
        assign bus.data_addr_i  = addr[g];
        assign bus.data_wdata_i = wdata[g];
        assign gnt[g]           = bus.data_gnt_o;
        assign rvalid[g]        = bus.data_rvalid_o;
        assign err[g]           = bus.data_err_o;
        assign rdata[g]         = bus.data_rdata_o;
        initial rv_cnt[g] = 0;
        always @(negedge clk) begin
            if (!rst_n) q.delete();
            else begin
                if (rvalid[g]) begin
                    rv_cnt[g]++;
                    last_rd[g]  = rdata[g];
                    last_err[g] = err[g];
                    if (q.size() == 0) chk("rsp_unexpected", 64'(rvalid[g]), 64'd0);
                    else begin
                        e = q.pop_front();
                        chk("rsp_data", {31'd0, err[g], rdata[g]}, {31'd0, e.err, e.rd});
                        chk("rsp_latency", 64'(cyc - e.c), 64'(RL));
                    end
                end
                if (gnt[g]) begin
                    off   = addr[g] - BASE;
                    wi    = off >> 2;
                    e.c   = cyc;
                    e.err = wi >= 32'd1024;
                    e.rd  = '0;
                    if (!e.err) begin
                        cur = mdl.exists(wi) ? mdl[wi] : 32'hx;
                        if (we[g]) begin
                            for (int i = 0; i < 4; i++) if (be[g][i]) cur[8*i +: 8] = wdata[g][8*i +: 8];
                            mdl[wi] = cur;
                        end else e.rd = cur;
                    end
                    q.push_back(e);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that follows the grant.
    task automatic xfer(input int k, input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, output int n);
        req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
        n = 0;
        @(negedge clk);
        while (!gnt[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("gnt_seen", 64'(gnt[k]), 64'd1);
        @(posedge clk); #1;
        req[k] = 1'b0;
    endtask

    task automatic burst(input int k, input logic w, input int cnt);
        int i = 0;
        int n = 0;
        req[k] = 1'b1; we[k] = w; be[k] = 4'hF; addr[k] = BASE; wdata[k] = 32'hA500_0000;
        while (i < cnt && n < 100) begin
            @(negedge clk);
            n++;
            if (gnt[k]) begin
                bg[i] = cyc;
                i++;
            end
            @(posedge clk); #1;
            addr[k] = BASE + 32'(4 * i); wdata[k] = 32'hA500_0000 + 32'(i);
        end
        req[k] = 1'b0;
        chk("burst_count", 64'(i), 64'(cnt));
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int k = 0; k < 4; k++)
            chk($sformatf("%s_%0d", tag, k), {30'd0, gnt[k], rvalid[k], err[k], rdata[k]}, 64'd0);
    endtask

    initial begin
        int n, c0;
        for (int k = 0; k < 4; k++) begin
            be[k] = '0; addr[k] = '0; wdata[k] = '0;
        end
        #1 rst_n = 1'b0;
        req = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset_state");
        @(posedge clk); #1;
        rst_n = 1'b1;
        req = '0;
        @(posedge clk); #1;
        // Instance 0: write/read, byte enables, out-of-range, back-to-back
        xfer(0, 1'b1, 4'hF, BASE + 32'h4, 32'hDEAD_BEEF, n);
        chk("a_gnt_same_cycle", 64'(n), 64'd0);
        xfer(0, 1'b0, 4'hF, BASE + 32'h4, 32'h0, n);
        settle();
        chk("a_rd_deadbeef", {31'd0, last_err[0], last_rd[0]}, {32'd0, 32'hDEAD_BEEF});
        xfer(0, 1'b1, 4'hF, BASE + 32'h8, 32'h1122_3344, n);
        xfer(0, 1'b1, 4'b0101, BASE + 32'h8, 32'hAABB_CCDD, n);
        xfer(0, 1'b0, 4'hF, BASE + 32'h8, 32'h0, n);
        settle();
        chk("a_be_merge", 64'(last_rd[0]), 64'h11BB_33DD);
        xfer(0, 1'b1, 4'hF, BASE, 32'hCAFE_F00D, n);
        xfer(0, 1'b0, 4'hF, 32'h0000_0000, 32'h0, n);
        settle();
        chk("a_oor_read", {31'd0, last_err[0], last_rd[0]}, {32'd1, 32'h0});
        xfer(0, 1'b1, 4'hF, BASE + 32'h1000, 32'h1234_5678, n);
        settle();
        chk("a_oor_write", {31'd0, last_err[0], last_rd[0]}, {32'd1, 32'h0});
        xfer(0, 1'b0, 4'hF, BASE, 32'h0, n);
        settle();
        chk("a_word0_intact", {31'd0, last_err[0], last_rd[0]}, {32'd0, 32'hCAFE_F00D});
        burst(0, 1'b0, 3);
        for (int i = 1; i < 3; i++) chk($sformatf("a_b2b_%0d", i), 64'(bg[i] - bg[0]), 64'(i));
        settle();
        // Instance 1: grant stall of 3, dropped request clears the stall count
        xfer(1, 1'b1, 4'hF, BASE + 32'h20, 32'h0BAD_C0DE, n);
        chk("b_stall_write", 64'(n), 64'd3);
        settle();
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = BASE + 32'h20;
        @(negedge clk);
        chk("b_drop_gnt0", 64'(gnt[1]), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b_drop_gnt1", 64'(gnt[1]), 64'd0);
        @(posedge clk); #1;
        req[1] = 1'b0;
        settle();
        chk("b_drop_no_rsp", 64'(g_dut[1].q.size()), 64'd0);
        xfer(1, 1'b0, 4'hF, BASE + 32'h20, 32'h0, n);
        chk("b_stall_after_drop", 64'(n), 64'd3);
        settle();
        chk("b_rd", 64'(last_rd[1]), 64'h0BAD_C0DE);
        // Instance 2: outstanding limit of 2 with latency 3
        burst(2, 1'b1, 6);
        for (int i = 1; i < 6; i++)
            chk($sformatf("c_wr_gnt_pat_%0d", i), 64'(bg[i] - bg[0]), 64'((i / 2) * 3 + i % 2));
        settle();
        burst(2, 1'b0, 6);
        for (int i = 1; i < 6; i++)
            chk($sformatf("c_rd_gnt_pat_%0d", i), 64'(bg[i] - bg[0]), 64'((i / 2) * 3 + i % 2));
        settle();
        chk("c_last_rd", 64'(last_rd[2]), 64'hA500_0005);
        // Instance 3: reset while a read is in flight
        xfer(3, 1'b1, 4'hF, BASE + 32'h10, 32'h600D_F00D, n);
        settle();
        c0 = rv_cnt[3];
        xfer(3, 1'b0, 4'hF, BASE + 32'h10, 32'h0, n);
        rst_n = 1'b0;
        req = 4'hF;
        @(negedge clk);
        chk_reset_outputs("midflight_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        req = '0;
        settle();
        chk("d_no_rvalid_after_reset", 64'(rv_cnt[3]), 64'(c0));
        xfer(3, 1'b0, 4'hF, BASE + 32'h10, 32'h0, n);
        settle();
        chk("d_write_survives_reset", {31'd0, last_err[3], last_rd[3]}, {32'd0, 32'h600D_F00D});
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
